// File: rtl/rx_symbol_demux.sv
// Receive framing demux: strips STP/SDP..END/EDB framing, forwards payload, decodes COM ordered sets.
// Latency: every output is registered one cycle after its symbol is sampled.
// Backpressure: none; one symbol is consumed every clock. Optional macro RX_ERR_CNT_EN adds err_count.
module rx_symbol_demux #(
    parameter int OS_LEN  = 4,   // ordered-set length including COM, 2..15
    parameter int MAX_PKT = 64,  // maximum payload bytes per packet
    parameter int LEN_W   = 7    // width of pkt_len, must hold MAX_PKT
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic [7:0]       D_in,
    input  logic             valid_in,
    output logic [7:0]       data_out,
    output logic             data_valid,
    output logic             sop,
    output logic             pkt_done,
    output logic [LEN_W-1:0] pkt_len,
    output logic             pkt_abort,
    output logic [7:0]       os_type,
    output logic             os_valid,
    output logic             framing_err
`ifdef RX_ERR_CNT_EN
    ,
    output logic [7:0]       err_count
`endif
);

    // Control symbols that steer the framer (SKP/IDL need no special handling:
    // they are ordinary K symbols in IDLE and ordinary type symbols in OSET).
    localparam logic [7:0] K_COM = 8'hBC;
    localparam logic [7:0] K_STP = 8'hFB;
    localparam logic [7:0] K_SDP = 8'h5C;
    localparam logic [7:0] K_END = 8'hFD;
    localparam logic [7:0] K_EDB = 8'hFE;

    localparam logic [3:0]       OS_LAST = 4'(OS_LEN);
    localparam logic [LEN_W-1:0] MAX_CNT = LEN_W'(MAX_PKT);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_PACKET = 2'd1,
        S_OSET   = 2'd2
    } state_t;

    state_t           state_q;
    logic [LEN_W-1:0] byte_cnt_q;
    logic [3:0]       os_cnt_q;
    logic             first_pending_q;
    logic [7:0]       type_q;

    logic [7:0]       data_out_q;
    logic             data_valid_q;
    logic             sop_q;
    logic             pkt_done_q;
    logic [LEN_W-1:0] pkt_len_q;
    logic             pkt_abort_q;
    logic [7:0]       os_type_q;
    logic             os_valid_q;
    logic             framing_err_q;

    // Framing FSM with registered outputs; pulses default low every cycle.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q         <= S_IDLE;
            byte_cnt_q      <= '0;
            os_cnt_q        <= '0;
            first_pending_q <= 1'b0;
            type_q          <= '0;
            data_out_q      <= '0;
            data_valid_q    <= 1'b0;
            sop_q           <= 1'b0;
            pkt_done_q      <= 1'b0;
            pkt_len_q       <= '0;
            pkt_abort_q     <= 1'b0;
            os_type_q       <= '0;
            os_valid_q      <= 1'b0;
            framing_err_q   <= 1'b0;
        end else begin
            data_valid_q  <= 1'b0;
            sop_q         <= 1'b0;
            pkt_done_q    <= 1'b0;
            pkt_abort_q   <= 1'b0;
            os_valid_q    <= 1'b0;
            framing_err_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (valid_in) begin
                        // Payload outside a packet is dropped.
                        framing_err_q <= 1'b1;
                    end else if (D_in == K_COM) begin
                        state_q  <= S_OSET;
                        os_cnt_q <= 4'd1;
                    end else if (D_in == K_STP || D_in == K_SDP) begin
                        state_q         <= S_PACKET;
                        byte_cnt_q      <= '0;
                        first_pending_q <= 1'b1;
                    end
                end

                S_PACKET: begin
                    if (valid_in) begin
                        if (byte_cnt_q < MAX_CNT) begin
                            data_out_q      <= D_in;
                            data_valid_q    <= 1'b1;
                            sop_q           <= first_pending_q;
                            first_pending_q <= 1'b0;
                            byte_cnt_q      <= byte_cnt_q + 1'b1;
                        end else begin
                            // Overlong packet: discard without forwarding this byte.
                            framing_err_q <= 1'b1;
                            pkt_abort_q   <= 1'b1;
                            state_q       <= S_IDLE;
                        end
                    end else begin
                        case (D_in)
                            K_END: begin
                                if (byte_cnt_q != '0) begin
                                    pkt_done_q <= 1'b1;
                                    pkt_len_q  <= byte_cnt_q;
                                end else begin
                                    framing_err_q <= 1'b1;
                                    pkt_abort_q   <= 1'b1;
                                end
                                state_q <= S_IDLE;
                            end
                            K_EDB: begin
                                // Transmitter nullified the packet: not an error.
                                pkt_abort_q <= 1'b1;
                                state_q     <= S_IDLE;
                            end
                            K_COM: begin
                                framing_err_q <= 1'b1;
                                pkt_abort_q   <= 1'b1;
                                state_q       <= S_OSET;
                                os_cnt_q      <= 4'd1;
                            end
                            K_STP, K_SDP: begin
                                framing_err_q   <= 1'b1;
                                pkt_abort_q     <= 1'b1;
                                byte_cnt_q      <= '0;
                                first_pending_q <= 1'b1;
                            end
                            default: begin
                                framing_err_q <= 1'b1;
                                pkt_abort_q   <= 1'b1;
                                state_q       <= S_IDLE;
                            end
                        endcase
                    end
                end

                S_OSET: begin
                    if (valid_in) begin
                        framing_err_q <= 1'b1;
                        state_q       <= S_IDLE;
                    end else if (D_in == K_COM) begin
                        // A fresh COM restarts the ordered set.
                        framing_err_q <= 1'b1;
                        os_cnt_q      <= 4'd1;
                    end else if (os_cnt_q == 4'd1) begin
                        type_q <= D_in;
                        if (OS_LAST == 4'd2) begin
                            os_valid_q <= 1'b1;
                            os_type_q  <= D_in;
                            state_q    <= S_IDLE;
                        end else begin
                            os_cnt_q <= 4'd2;
                        end
                    end else if (D_in != type_q) begin
                        framing_err_q <= 1'b1;
                        state_q       <= S_IDLE;
                    end else if (os_cnt_q + 4'd1 == OS_LAST) begin
                        os_valid_q <= 1'b1;
                        os_type_q  <= type_q;
                        state_q    <= S_IDLE;
                    end else begin
                        os_cnt_q <= os_cnt_q + 4'd1;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign data_out    = data_out_q;
    assign data_valid  = data_valid_q;
    assign sop         = sop_q;
    assign pkt_done    = pkt_done_q;
    assign pkt_len     = pkt_len_q;
    assign pkt_abort   = pkt_abort_q;
    assign os_type     = os_type_q;
    assign os_valid    = os_valid_q;
    assign framing_err = framing_err_q;

`ifdef RX_ERR_CNT_EN
    logic [7:0] err_cnt_q;

    // Saturating count of framing_err pulses, sticks at FF.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            err_cnt_q <= '0;
        end else if (framing_err_q && err_cnt_q != 8'hFF) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_rx_symbol_demux.sv
`timescale 1ns/1ps
module tb_rx_symbol_demux;

    localparam logic [7:0] K_COM = 8'hBC, K_STP = 8'hFB, K_SDP = 8'h5C, K_END = 8'hFD;
    localparam logic [7:0] K_EDB = 8'hFE, K_SKP = 8'h1C, K_IDL = 8'h7C, K_FTS = 8'h3C;

    typedef struct packed {
        logic [7:0] dout;
        logic       dv;
        logic       sop;
        logic       done;
        logic [6:0] len;
        logic       abort;
        logic [7:0] ost;
        logic       osv;
        logic       ferr;
    } obs_t;

    typedef struct packed {
        logic [7:0] sym;
        logic       dat;
        obs_t       exp;
    } vec_t;

    logic       clk;
    logic       reset_L;
    logic [7:0] D_in;
    logic       valid_in;
    logic [7:0] data_out;
    logic       data_valid;
    logic       sop;
    logic       pkt_done;
    logic [6:0] pkt_len;
    logic       pkt_abort;
    logic [7:0] os_type;
    logic       os_valid;
    logic       framing_err;
`ifdef RX_ERR_CNT_EN
    logic [7:0] err_count;
`endif

    int         n_vec = 0;
    int         n_mis = 0;
    obs_t       sb_q[$];
    logic [7:0] ost_track = 8'h00;

    // Short MAX_PKT so the overflow boundary is reachable with a handful of bytes.
    rx_symbol_demux #(.OS_LEN(4), .MAX_PKT(4), .LEN_W(7)) dut (
        .clk        (clk),
        .reset_L    (reset_L),
        .D_in       (D_in),
        .valid_in   (valid_in),
        .data_out   (data_out),
        .data_valid (data_valid),
        .sop        (sop),
        .pkt_done   (pkt_done),
        .pkt_len    (pkt_len),
        .pkt_abort  (pkt_abort),
        .os_type    (os_type),
        .os_valid   (os_valid),
        .framing_err(framing_err)
`ifdef RX_ERR_CNT_EN
        ,
        .err_count  (err_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic obs_t x_idle();
        obs_t o = '0;
        return o;
    endfunction
    function automatic obs_t x_d(logic [7:0] b, logic s);
        obs_t o = '0;
        o.dout = b; o.dv = 1'b1; o.sop = s;
        return o;
    endfunction
    function automatic obs_t x_done(logic [6:0] l);
        obs_t o = '0;
        o.done = 1'b1; o.len = l;
        return o;
    endfunction
    function automatic obs_t x_ab(logic f);
        obs_t o = '0;
        o.abort = 1'b1; o.ferr = f;
        return o;
    endfunction
    function automatic obs_t x_fe();
        obs_t o = '0;
        o.ferr = 1'b1;
        return o;
    endfunction
    function automatic obs_t x_os(logic [7:0] t);
        obs_t o = '0;
        o.osv = 1'b1; o.ost = t;
        return o;
    endfunction
    function automatic vec_t v(logic [7:0] s, logic d, obs_t e);
        vec_t r;
        r.sym = s; r.dat = d; r.exp = e;
        return r;
    endfunction

    // Fields that are meaningless this cycle are masked to zero.
    function automatic obs_t observe();
        obs_t o;
        o.dout  = data_valid ? data_out : 8'h00;
        o.dv    = data_valid;
        o.sop   = sop;
        o.done  = pkt_done;
        o.len   = pkt_done ? pkt_len : 7'd0;
        o.abort = pkt_abort;
        o.ost   = os_type;
        o.osv   = os_valid;
        o.ferr  = framing_err;
        return o;
    endfunction

    function automatic logic [29:0] raw();
        return {data_out, data_valid, sop, pkt_done, pkt_len, pkt_abort, os_type, os_valid, framing_err};
    endfunction

    // Drive one symbol (called at a negedge), record its expected outputs, advance to the next negedge.
    task automatic apply(input vec_t t);
        obs_t e = t.exp;
        D_in     = t.sym;
        valid_in = t.dat;
        if (e.osv) ost_track = e.ost;
        e.ost = ost_track;
        sb_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle_in();
        D_in     = K_IDL;
        valid_in = 1'b0;
    endtask

    task automatic test_reset();
        vec_t seq[$];
        obs_t exp, got;
        repeat (2) @(negedge clk);
        n_vec++;
        if (raw() !== 30'd0) begin n_mis++; $display("FAIL reset_initial got=%h want=0", raw()); end
        reset_L = 1'b1;
        seq.push_back(v(K_STP, 1'b0, x_idle()));
        seq.push_back(v(8'h11, 1'b1, x_d(8'h11, 1'b1)));
        seq.push_back(v(8'h22, 1'b1, x_d(8'h22, 1'b0)));
        foreach (seq[i]) begin
            apply(seq[i]);
            exp = sb_q.pop_front(); got = observe(); n_vec++;
            if (got !== exp) begin n_mis++; $display("FAIL reset_pre[%0d] got=%h want=%h", i, got, exp); end
        end
        idle_in();
        reset_L   = 1'b0;
        ost_track = 8'h00;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_vec++;
            if (raw() !== 30'd0) begin n_mis++; $display("FAIL reset_mid_pkt[%0d] got=%h want=0", c, raw()); end
        end
        reset_L = 1'b1;
        seq.delete();
        seq.push_back(v(K_END, 1'b0, x_idle()));
        seq.push_back(v(K_IDL, 1'b0, x_idle()));
        foreach (seq[i]) begin
            apply(seq[i]);
            exp = sb_q.pop_front(); got = observe(); n_vec++;
            if (got !== exp) begin n_mis++; $display("FAIL reset_post[%0d] got=%h want=%h", i, got, exp); end
        end
        idle_in();
    endtask

    task automatic test_good_packet();
        vec_t seq[$];
        obs_t exp, got;
        seq.push_back(v(K_STP, 1'b0, x_idle()));
        seq.push_back(v(8'h11, 1'b1, x_d(8'h11, 1'b1)));
        seq.push_back(v(8'h22, 1'b1, x_d(8'h22, 1'b0)));
        seq.push_back(v(8'h33, 1'b1, x_d(8'h33, 1'b0)));
        seq.push_back(v(K_END, 1'b0, x_done(7'd3)));
        seq.push_back(v(K_IDL, 1'b0, x_idle()));
        foreach (seq[i]) begin
            apply(seq[i]);
            exp = sb_q.pop_front(); got = observe(); n_vec++;
            if (got !== exp) begin n_mis++; $display("FAIL good_packet[%0d] got=%h want=%h", i, got, exp); end
        end
        idle_in();
    endtask

    task automatic test_ordered_set();
        vec_t seq[$];
        obs_t exp, got;
        seq.push_back(v(K_COM, 1'b0, x_idle()));
        seq.push_back(v(K_SKP, 1'b0, x_idle()));
        seq.push_back(v(K_SKP, 1'b0, x_idle()));
        seq.push_back(v(K_SKP, 1'b0, x_os(8'h1C)));
        seq.push_back(v(K_IDL, 1'b0, x_idle()));
        // Second set with a different type: os_type must move and then hold.
        seq.push_back(v(K_COM, 1'b0, x_idle()));
        seq.push_back(v(K_IDL, 1'b0, x_idle()));
        seq.push_back(v(K_IDL, 1'b0, x_idle()));
        seq.push_back(v(K_IDL, 1'b0, x_os(8'h7C)));
        seq.push_back(v(K_IDL, 1'b0, x_idle()));
        seq.push_back(v(K_IDL, 1'b0, x_idle()));
        foreach (seq[i]) begin
            apply(seq[i]);
            exp = sb_q.pop_front(); got = observe(); n_vec++;
            if (got !== exp) begin n_mis++; $display("FAIL ordered_set[%0d] got=%h want=%h", i, got, exp); end
        end
        idle_in();
    endtask

    task automatic test_nullify();
        vec_t seq[$];
        obs_t exp, got;
        seq.push_back(v(K_SDP, 1'b0, x_idle()));
        seq.push_back(v(8'hAA, 1'b1, x_d(8'hAA, 1'b1)));
        seq.push_back(v(K_EDB, 1'b0, x_ab(1'b0)));
        seq.push_back(v(K_IDL, 1'b0, x_idle()));
        foreach (seq[i]) begin
            apply(seq[i]);
            exp = sb_q.pop_front(); got = observe(); n_vec++;
            if (got !== exp) begin n_mis++; $display("FAIL nullify[%0d] got=%h want=%h", i, got, exp); end
        end
        idle_in();
    endtask

    task automatic test_overflow();
        vec_t seq[$];
        obs_t exp, got;
        seq.push_back(v(K_STP, 1'b0, x_idle()));
        seq.push_back(v(8'h01, 1'b1, x_d(8'h01, 1'b1)));
        seq.push_back(v(8'h02, 1'b1, x_d(8'h02, 1'b0)));
        seq.push_back(v(8'h03, 1'b1, x_d(8'h03, 1'b0)));
        seq.push_back(v(8'h04, 1'b1, x_d(8'h04, 1'b0)));
        seq.push_back(v(8'h05, 1'b1, x_ab(1'b1)));
        seq.push_back(v(K_END, 1'b0, x_idle()));
        seq.push_back(v(K_IDL, 1'b0, x_idle()));
        foreach (seq[i]) begin
            apply(seq[i]);
            exp = sb_q.pop_front(); got = observe(); n_vec++;
            if (got !== exp) begin n_mis++; $display("FAIL overflow[%0d] got=%h want=%h", i, got, exp); end
        end
        idle_in();
    endtask

    task automatic test_framing_faults();
        vec_t seq[$];
        obs_t exp, got;
        reset_L = 1'b0;
        @(negedge clk);
        reset_L   = 1'b1;
        ost_track = 8'h00;
`ifdef RX_ERR_CNT_EN
        n_vec++;
        if (err_count !== 8'd0) begin n_mis++; $display("FAIL err_count_reset got=%0d want=0", err_count); end
`endif
        seq.push_back(v(8'h55, 1'b1, x_fe()));
        seq.push_back(v(K_IDL, 1'b0, x_idle()));
        seq.push_back(v(K_COM, 1'b0, x_idle()));
        seq.push_back(v(K_SKP, 1'b0, x_idle()));
        seq.push_back(v(K_FTS, 1'b0, x_fe()));
        seq.push_back(v(K_IDL, 1'b0, x_idle()));
        seq.push_back(v(K_IDL, 1'b0, x_idle()));
        foreach (seq[i]) begin
            apply(seq[i]);
            exp = sb_q.pop_front(); got = observe(); n_vec++;
            if (got !== exp) begin n_mis++; $display("FAIL framing_faults[%0d] got=%h want=%h", i, got, exp); end
        end
        idle_in();
`ifdef RX_ERR_CNT_EN
        n_vec++;
        if (err_count !== 8'd2) begin n_mis++; $display("FAIL err_count got=%0d want=2", err_count); end
`endif
    endtask

    task automatic test_back_to_back();
        vec_t seq[$];
        obs_t exp, got;
        // Exactly MAX_PKT bytes, then an immediate second packet restarted by SDP.
        seq.push_back(v(K_STP, 1'b0, x_idle()));
        seq.push_back(v(8'h01, 1'b1, x_d(8'h01, 1'b1)));
        seq.push_back(v(8'h02, 1'b1, x_d(8'h02, 1'b0)));
        seq.push_back(v(8'h03, 1'b1, x_d(8'h03, 1'b0)));
        seq.push_back(v(8'h04, 1'b1, x_d(8'h04, 1'b0)));
        seq.push_back(v(K_END, 1'b0, x_done(7'd4)));
        seq.push_back(v(K_STP, 1'b0, x_idle()));
        seq.push_back(v(8'hA1, 1'b1, x_d(8'hA1, 1'b1)));
        seq.push_back(v(K_SDP, 1'b0, x_ab(1'b1)));
        seq.push_back(v(8'hB1, 1'b1, x_d(8'hB1, 1'b1)));
        seq.push_back(v(K_END, 1'b0, x_done(7'd1)));
        // Empty packet.
        seq.push_back(v(K_STP, 1'b0, x_idle()));
        seq.push_back(v(K_END, 1'b0, x_ab(1'b1)));
        // COM inside a packet starts an ordered set.
        seq.push_back(v(K_STP, 1'b0, x_idle()));
        seq.push_back(v(8'hC1, 1'b1, x_d(8'hC1, 1'b1)));
        seq.push_back(v(K_COM, 1'b0, x_ab(1'b1)));
        seq.push_back(v(K_SKP, 1'b0, x_idle()));
        seq.push_back(v(K_SKP, 1'b0, x_idle()));
        seq.push_back(v(K_SKP, 1'b0, x_os(8'h1C)));
        // Repeated COM restarts the ordered set.
        seq.push_back(v(K_COM, 1'b0, x_idle()));
        seq.push_back(v(K_COM, 1'b0, x_fe()));
        seq.push_back(v(K_SKP, 1'b0, x_idle()));
        seq.push_back(v(K_SKP, 1'b0, x_idle()));
        seq.push_back(v(K_SKP, 1'b0, x_os(8'h1C)));
        // Data inside an ordered set, then an unexpected K inside a packet.
        seq.push_back(v(K_COM, 1'b0, x_idle()));
        seq.push_back(v(8'h77, 1'b1, x_fe()));
        seq.push_back(v(K_STP, 1'b0, x_idle()));
        seq.push_back(v(K_IDL, 1'b0, x_ab(1'b1)));
        seq.push_back(v(K_IDL, 1'b0, x_idle()));
        foreach (seq[i]) begin
            apply(seq[i]);
            exp = sb_q.pop_front(); got = observe(); n_vec++;
            if (got !== exp) begin n_mis++; $display("FAIL back_to_back[%0d] got=%h want=%h", i, got, exp); end
        end
        idle_in();
    endtask

    initial begin
        reset_L  = 1'b0;
        D_in     = K_IDL;
        valid_in = 1'b0;
        test_reset();
        test_good_packet();
        test_ordered_set();
        test_nullify();
        test_overflow();
        test_back_to_back();
        test_framing_faults();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
